// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit.
// Runs one request/acknowledge transaction per operation on a word-wide data
// port. It builds byte enables and lane-replicated store data, and sign- or
// zero-extends load data. Misaligned accesses complete without a memory request.
module load_store_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Busy,
    output logic        Done,
    output logic        Misaligned,
    output logic [31:0] LoadData,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBe,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] load_data_q, load_data_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    // Request-side decode of the incoming operation.
    logic        req_is_store;
    logic        req_misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    // Classify the incoming op by access size and build enables/write data.
    always_comb begin
        req_is_store   = (Op == OP_SB) || (Op == OP_SH) || (Op == OP_SW);
        req_misaligned = 1'b0;
        req_be         = 4'b1111;
        req_wdata      = StoreData;
        case (Op)
            OP_LB, OP_LBU, OP_SB: begin
                req_be    = 4'b0001 << Addr[1:0];
                req_wdata = {4{StoreData[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                req_misaligned = Addr[0];
                req_be         = Addr[1] ? 4'b1100 : 4'b0011;
                req_wdata      = {2{StoreData[15:0]}};
            end
            default: begin
                req_misaligned = |Addr[1:0];
                req_be         = 4'b1111;
                req_wdata      = StoreData;
            end
        endcase
    end

    // Response-side lane selection and extension of the returned word.
    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;
    logic        op_is_load;

    // Select the addressed lane from MemRData and extend it per the latched op.
    always_comb begin
        rd_shift   = MemRData >> {addr_lo_q, 3'b000};
        rd_byte    = rd_shift[7:0];
        rd_half    = addr_lo_q[1] ? MemRData[31:16] : MemRData[15:0];
        op_is_load = !((op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW));
        case (op_q)
            OP_LB:   rd_ext = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  rd_ext = {24'd0, rd_byte};
            OP_LH:   rd_ext = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  rd_ext = {16'd0, rd_half};
            OP_LW:   rd_ext = MemRData;
            default: rd_ext = load_data_q;
        endcase
    end

    // Next-state and next-output logic; every output is taken from a flop.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_lo_d    = addr_lo_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        misaligned_d = 1'b0;
        load_data_d  = load_data_q;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                // RESP accepts a new Start exactly like IDLE, which gives
                // back-to-back operations every second cycle.
                state_d = S_IDLE;
                if (Start) begin
                    if (req_misaligned) begin
                        state_d      = S_RESP;
                        done_d       = 1'b1;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        op_d        = Op;
                        addr_lo_d   = Addr[1:0];
                        busy_d      = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_is_store;
                        mem_addr_d  = {Addr[31:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_wdata;
                    end
                end
            end
            S_REQ: begin
                if (MemAck) begin
                    state_d = S_RESP;
                    done_d  = 1'b1;
                    if (op_is_load) begin
                        load_data_d = rd_ext;
                    end
                end else begin
                    // Hold the request unchanged until it is acknowledged.
                    busy_d    = 1'b1;
                    mem_req_d = 1'b1;
                    mem_we_d  = mem_we_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            op_q         <= 3'b000;
            addr_lo_q    <= 2'b00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            load_data_q  <= 32'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_lo_q    <= addr_lo_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            misaligned_q <= misaligned_d;
            load_data_q  <= load_data_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Misaligned = misaligned_q;
    assign LoadData   = load_data_q;
    assign MemReq     = mem_req_q;
    assign MemWe      = mem_we_q;
    assign MemAddr    = mem_addr_q;
    assign MemBe      = mem_be_q;
    assign MemWData   = mem_wdata_q;

endmodule
